// File: rtl/camera_pkg.sv
// camera_pkg: shared types and constants for the camera_ctrl_multi block.
//   cam_state_e  - controller FSM state (IDLE / EXPOSE / READ)
//   ROW_CYCLES   - clk cycles spent on each readout row (select, then convert)
//   row_cnt_w()  - row counter width, max(1, clog2(rows))
package camera_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPOSE = 2'd1,
    ST_READ   = 2'd2
  } cam_state_e;

  localparam int unsigned ROW_CYCLES = 2;

  function automatic int unsigned row_cnt_w(input int unsigned rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/exposure_reg.sv
// exposure_reg: saturating up/down exposure-time register.
// Parameters: EXP_W (width), EXP_MIN/EXP_MAX (saturation limits),
//             EXP_RESET (value after reset).
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   inc, dec    - step up / down by one per enabled cycle (both = hold)
//   enable      - updates only take effect while high
//   value       - current exposure time in clk cycles
module exposure_reg
  import camera_pkg::*;
#(
  parameter int unsigned EXP_W     = 5,
  parameter int unsigned EXP_MIN   = 2,
  parameter int unsigned EXP_MAX   = 30,
  parameter int unsigned EXP_RESET = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             enable,
  output logic [EXP_W-1:0] value
);

  logic [EXP_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (enable) begin
      if (inc && !dec && (value_q < EXP_W'(EXP_MAX))) begin
        value_d = value_q + EXP_W'(1);
      end else if (dec && !inc && (value_q > EXP_W'(EXP_MIN))) begin
        value_d = value_q - EXP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= EXP_W'(EXP_RESET);
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/camera_ctrl_multi.sv
// camera_ctrl_multi: erase / expose / row-by-row ADC readout sequencer for a
// pixel array with ROWS readout rows.
// Ports:
//   clk, reset         - clock, asynchronous active-low reset
//   init               - start-frame strobe (sampled only when idle)
//   exp_inc, exp_dec   - exposure adjust while idle (saturating)
//   cont               - continuous capture request (CAMERA_CONT_EN only)
//   nre[ROWS-1:0]      - active-low row read enables, one-cold during readout
//   expose, erase, adc - pixel expose, pixel erase, ADC convert strobe
//   busy               - high whenever a frame is in progress
//   frame_done         - one-cycle pulse after the last row conversion
// Build option: define CAMERA_CONT_EN to add the cont port and free-running
// back-to-back frames.
module camera_ctrl_multi
  import camera_pkg::*;
#(
  parameter int unsigned ROWS      = 2,
  parameter int unsigned EXP_W     = 5,
  parameter int unsigned EXP_MIN   = 2,
  parameter int unsigned EXP_MAX   = 30,
  parameter int unsigned EXP_RESET = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            init,
  input  logic            exp_inc,
  input  logic            exp_dec,
`ifdef CAMERA_CONT_EN
  input  logic            cont,
`endif
  output logic [ROWS-1:0] nre,
  output logic            expose,
  output logic            erase,
  output logic            adc,
  output logic            busy,
  output logic            frame_done
);

  localparam int unsigned RW = row_cnt_w(ROWS);

  cam_state_e       state_q, state_d;
  logic [EXP_W-1:0] exp_time;
  logic [EXP_W-1:0] exp_cnt_q, exp_cnt_d;
  logic [RW-1:0]    row_q, row_d;
  logic             phase_q, phase_d;
  logic             done_d;
  logic [ROWS-1:0]  nre_d;
  logic             cont_w;

`ifdef CAMERA_CONT_EN
  assign cont_w = cont;
`else
  assign cont_w = 1'b0;
`endif

  exposure_reg #(
    .EXP_W    (EXP_W),
    .EXP_MIN  (EXP_MIN),
    .EXP_MAX  (EXP_MAX),
    .EXP_RESET(EXP_RESET)
  ) u_exposure_reg (
    .clk   (clk),
    .reset (reset),
    .inc   (exp_inc),
    .dec   (exp_dec),
    .enable(!busy),
    .value (exp_time)
  );

  // Each row spends ROW_CYCLES (2) cycles: phase 0 selects, phase 1 converts.
  always_comb begin
    state_d   = state_q;
    exp_cnt_d = exp_cnt_q;
    row_d     = row_q;
    phase_d   = phase_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (init) begin
          state_d   = ST_EXPOSE;
          exp_cnt_d = exp_time;
        end
      end
      ST_EXPOSE: begin
        if (exp_cnt_q == EXP_W'(1)) begin
          state_d = ST_READ;
          row_d   = '0;
          phase_d = 1'b0;
        end else begin
          exp_cnt_d = exp_cnt_q - EXP_W'(1);
        end
      end
      ST_READ: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (row_q == RW'(ROWS - 1)) begin
          done_d  = 1'b1;
          phase_d = 1'b0;
          row_d   = '0;
          if (cont_w) begin
            state_d   = ST_EXPOSE;
            exp_cnt_d = exp_time;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          row_d   = row_q + RW'(1);
          phase_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register on the same
  // edge as the state they describe.
  always_comb begin
    nre_d = '1;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if ((state_d == ST_READ) && (row_d == RW'(r))) begin
        nre_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      exp_cnt_q  <= '0;
      row_q      <= '0;
      phase_q    <= 1'b0;
      nre        <= '1;
      expose     <= 1'b0;
      erase      <= 1'b1;
      adc        <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_cnt_q  <= exp_cnt_d;
      row_q      <= row_d;
      phase_q    <= phase_d;
      nre        <= nre_d;
      expose     <= (state_d == ST_EXPOSE);
      erase      <= (state_d == ST_IDLE);
      adc        <= (state_d == ST_READ) && phase_d;
      busy       <= (state_d != ST_IDLE);
      frame_done <= done_d;
    end
  end

endmodule

// File: tb/tb_camera_ctrl_multi.sv
// Bench for camera_ctrl_multi: a ROWS=2 and a ROWS=4 instance share stimulus;
// a frame-position model predicts every output each cycle, and directed
// frames are checked against hand-computed values.
module tb_camera_ctrl_multi;

  logic clk;
  logic rst  = 1'b0;
  logic init = 1'b0;
  logic inc  = 1'b0;
  logic dec  = 1'b0;
  logic cont = 1'b0;

  logic [1:0] nre2;
  logic       expose2, erase2, adc2, busy2, done2;
  logic [3:0] nre4;
  logic       expose4, erase4, adc4, busy4, done4;

  int n_checks = 0;
  int n_fail   = 0;

  camera_ctrl_multi #(.ROWS(2)) u2 (
    .clk(clk), .reset(rst), .init(init), .exp_inc(inc), .exp_dec(dec),
`ifdef CAMERA_CONT_EN
    .cont(cont),
`endif
    .nre(nre2), .expose(expose2), .erase(erase2), .adc(adc2),
    .busy(busy2), .frame_done(done2)
  );

  camera_ctrl_multi #(.ROWS(4)) u4 (
    .clk(clk), .reset(rst), .init(init), .exp_inc(inc), .exp_dec(dec),
`ifdef CAMERA_CONT_EN
    .cont(cont),
`endif
    .nre(nre4), .expose(expose4), .erase(erase4), .adc(adc4),
    .busy(busy4), .frame_done(done4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Model: exposure value, plus position m_t within the current frame of
  // length m_T + 2*rows.
  int m_exp[2];
  int m_T[2];
  int m_t[2];
  bit m_busy[2];
  bit m_done[2];

  function automatic int rows_of(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_exp[i] = 2; m_T[i] = 0; m_t[i] = 0; m_busy[i] = 0; m_done[i] = 0;
    end
    forever begin
      @(posedge clk or negedge rst);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (!rst) begin
          m_exp[i] = 2; m_T[i] = 0; m_t[i] = 0; m_busy[i] = 0; m_done[i] = 0;
        end else begin
          m_done[i] = 0;
          if (!m_busy[i]) begin
            if (init) begin
              m_busy[i] = 1; m_T[i] = m_exp[i]; m_t[i] = 0;
            end
            if (inc && !dec && m_exp[i] < 30) m_exp[i]++;
            else if (dec && !inc && m_exp[i] > 2) m_exp[i]--;
          end else begin
            m_t[i]++;
            if (m_t[i] == m_T[i] + 2 * rows_of(i)) begin
              m_done[i] = 1;
              if (cont) begin
                m_t[i] = 0; m_T[i] = m_exp[i];
              end else begin
                m_busy[i] = 0;
              end
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the clock edges.
  initial begin
    logic [3:0] en;
    bit ex, ad, bs;
    int k;
    forever begin
      @(posedge clk);
      #4;
      for (int i = 0; i < 2; i++) begin
        bs = m_busy[i];
        ex = bs && (m_t[i] < m_T[i]);
        en = 4'hF;
        ad = 0;
        if (bs && m_t[i] >= m_T[i]) begin
          k  = m_t[i] - m_T[i];
          en = ~(4'(1) << (k / 2));
          ad = (k % 2) == 1;
        end
        if (i == 0) begin
          chk("u2 nre", nre2, en[1:0]);
          chk("u2 expose", expose2, ex);
          chk("u2 erase", erase2, !bs);
          chk("u2 adc", adc2, ad);
          chk("u2 busy", busy2, bs);
          chk("u2 frame_done", done2, m_done[0]);
        end else begin
          chk("u4 nre", nre4, en);
          chk("u4 expose", expose4, ex);
          chk("u4 erase", erase4, !bs);
          chk("u4 adc", adc4, ad);
          chk("u4 busy", busy4, bs);
          chk("u4 frame_done", done4, m_done[1]);
        end
      end
    end
  end

  // Frame recorder: k = number of edges since the init edge E0.
  logic [41:0] e2, a2, d2, b2, r2, e4, a4, d4, b4, r4;
  logic [1:0]  n2 [42];
  logic [3:0]  n4 [42];
  logic [3:0]  walk [8] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101,
                            4'b1011, 4'b1011, 4'b0111, 4'b0111};

  function automatic int first_one(input logic [41:0] v);
    for (int i = 0; i < 42; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic run_frame(input bit poke);
    init = 1'b1;
    for (int k = 0; k < 42; k++) begin
      @(negedge clk);
      if (k == 0) init = 1'b0;
      if (poke && k == 1) begin init = 1'b1; inc = 1'b1; end
      if (poke && k == 3) begin init = 1'b0; inc = 1'b0; end
      e2[k] = expose2; a2[k] = adc2; d2[k] = done2; b2[k] = busy2; r2[k] = erase2; n2[k] = nre2;
      e4[k] = expose4; a4[k] = adc4; d4[k] = done4; b4[k] = busy4; r4[k] = erase4; n4[k] = nre4;
    end
  endtask

  task automatic hold(input logic i_inc, input logic i_dec, input int n);
    inc = i_inc; dec = i_dec;
    repeat (n) @(negedge clk);
    inc = 1'b0; dec = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset erase", erase2, 1);
    chk("reset busy", busy2, 0);
    chk("reset nre2", nre2, 2'b11);
    chk("reset nre4", nre4, 4'hF);
    chk("reset adc", adc2, 0);
    chk("reset expose", expose2, 0);
    chk("reset frame_done", done2, 0);
    rst = 1'b1;
    @(negedge clk);

    // 20 increments then a frame: exp_time 22, 26-cycle frame
    hold(1'b1, 1'b0, 20);
    chk("model exp after 20 inc", m_exp[0], 22);
    run_frame(0);
    chk("E0 expose", e2[0], 1);
    chk("E0 erase", r2[0], 0);
    chk("expose cycles 22", $countones(e2), 22);
    chk("nre k22", n2[22], 2'b10);
    chk("nre k23", n2[23], 2'b10);
    chk("nre k24", n2[24], 2'b01);
    chk("nre k25", n2[25], 2'b01);
    chk("adc k22", a2[22], 0);
    chk("adc k23", a2[23], 1);
    chk("adc k24", a2[24], 0);
    chk("adc k25", a2[25], 1);
    chk("frame_done at 26", first_one(d2), 26);
    chk("frame_done once", $countones(d2), 1);
    chk("busy k25", b2[25], 1);
    chk("busy k26", b2[26], 0);
    chk("erase k26", r2[26], 1);
    chk("u4 frame len 30", first_one(d4), 30);

    // Saturation high / low, both-held hold
    hold(1'b1, 1'b0, 40);
    run_frame(0);
    chk("sat max expose", $countones(e2), 30);
    chk("sat max frame", first_one(d2), 34);
    chk("sat max u4 frame", first_one(d4), 38);
    hold(1'b0, 1'b1, 40);
    run_frame(0);
    chk("sat min expose", $countones(e2), 2);
    chk("sat min frame", first_one(d2), 6);
    hold(1'b1, 1'b0, 3);
    hold(1'b1, 1'b1, 5);
    run_frame(0);
    chk("both held expose", $countones(e2), 5);
    chk("both held frame", first_one(d2), 9);

    // Lockout: inc and init during EXPOSE are ignored
    run_frame(1);
    chk("lockout expose", $countones(e2), 5);
    chk("lockout frame", first_one(d2), 9);
    chk("lockout single frame", $countones(d2), 1);
    run_frame(0);
    chk("lockout exp kept", $countones(e2), 5);

    // ROWS=4 with exp_time 3
    hold(1'b0, 1'b1, 2);
    run_frame(0);
    chk("u4 expose 3", $countones(e4), 3);
    for (int j = 0; j < 8; j++) chk($sformatf("u4 walk %0d", j), n4[3 + j], walk[j]);
    chk("u4 adc pulses", $countones(a4), 4);
    chk("u4 frame_done at 11", first_one(d4), 11);

    // Asynchronous reset mid-READ with nre[1] low
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-reset nre2", nre2, 2'b01);
    #2 rst = 1'b0;
    #1;
    chk("mid reset nre2", nre2, 2'b11);
    chk("mid reset nre4", nre4, 4'hF);
    chk("mid reset adc", adc2, 0);
    chk("mid reset erase", erase2, 1);
    chk("mid reset busy", busy2, 0);
    chk("mid reset busy4", busy4, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_frame(0);
    chk("post reset expose", $countones(e2), 2);
    chk("post reset frame", first_one(d2), 6);

`ifdef CAMERA_CONT_EN
    // Continuous capture, exp_time 2: u2 frames every 6, u4 every 10
    cont = 1'b1;
    init = 1'b1;
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      if (k == 0) init = 1'b0;
      if (k == 14) cont = 1'b0;
      e2[k] = expose2; d2[k] = done2; b2[k] = busy2; r2[k] = erase2;
      d4[k] = done4; b4[k] = busy4; r4[k] = erase4;
    end
    chk("cont erase low", $countones(r2[17:0]), 0);
    chk("cont done 6", d2[6], 1);
    chk("cont done 12", d2[12], 1);
    chk("cont done 18", d2[18], 1);
    chk("cont done count", $countones(d2[25:0]), 3);
    chk("cont expose k6", e2[6], 1);
    chk("cont end busy", b2[18], 0);
    chk("cont end erase", r2[18], 1);
    chk("cont u4 done 10", d4[10], 1);
    chk("cont u4 done 20", d4[20], 1);
    chk("cont u4 erase low", $countones(r4[19:0]), 0);
    chk("cont u4 idle", b4[20], 0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/camera_ctrl_multi.md
# camera_ctrl_multi

Parametrised successor to the pixel-array camera controller. It sequences an erase, expose and row-by-row ADC readout cycle for an array with `ROWS` readout rows. Exposure time is user-adjustable, saturating and range-limited. A compile-time option adds continuous (free-running) capture. The block sits between the operator buttons/host strobes and the analog pixel array plus ADC.

## Interface
- `ROWS`, 2: number of readout rows; one active-low row enable per row; ≥1.
- `EXP_W`, 5: exposure register width; must hold `EXP_MAX`.
- `EXP_MIN`, 2: minimum exposure, in clk cycles; ≥1.
- `EXP_MAX`, 30: maximum exposure, in clk cycles; ≤ 2^EXP_W−1.
- `EXP_RESET`, 2: exposure value after reset; EXP_MIN ≤ EXP_RESET ≤ EXP_MAX.

Ports:
- `clk` in 1: system clock (1 kHz nominal); all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `init` in 1: start-frame strobe; sampled only in IDLE.
- `exp_inc` in 1: increment exposure by 1 per cycle while high.
- `exp_dec` in 1: decrement exposure by 1 per cycle while high.
- `cont` in 1: continuous-capture request; present only with `CAMERA_CONT_EN`.
- `nre` out ROWS: row read enables, active low; `nre[r]` selects row r.
- `expose` out 1: pixel expose control.
- `erase` out 1: pixel erase control.
- `adc` out 1: ADC convert strobe.
- `busy` out 1: high in any state other than IDLE.
- `frame_done` out 1: one-cycle pulse after the last row conversion.

## Operation
- Every output is registered and changes only on a `clk` rising edge or on `reset`.
- Reset values:
  - state = IDLE
  - `exp_time` = EXP_RESET
  - `erase` = 1, `expose` = 0, `nre` = all 1s, `adc` = 0, `busy` = 0, `frame_done` = 0
- The FSM has three states: IDLE, EXPOSE and READ.
- IDLE:
  - `erase` = 1.
  - `exp_time` updates each cycle:
    - `exp_inc` & !`exp_dec` → +1, saturating at EXP_MAX.
    - `exp_dec` & !`exp_inc` → −1, saturating at EXP_MIN.
    - Both or neither → hold.
  - `init` = 1 → EXPOSE. `exp_time` is copied into `exp_cnt` on the same edge.
- EXPOSE:
  - `erase` = 0, `expose` = 1.
  - `exp_cnt` decrements each cycle. When it reaches 1, the next state is READ.
- READ:
  - `expose` = 0.
  - Each row r occupies 2 cycles, with `nre[r]` = 0 for both. `adc` = 0 in the first cycle and 1 in the second.
  - Rows are read in order 0 … ROWS−1. Only one `nre` bit is low at a time.
  - After the last row: `frame_done` = 1 for one cycle, then → IDLE.
- `exp_inc`, `exp_dec` and `init` are ignored while `busy`. `exp_time` cannot change mid-frame.
- Asserting `reset` mid-frame immediately forces all reset values. No partial readout completes.

## Timing
- `init` is sampled at edge E0. At E0, `busy` = 1, `expose` = 1 and `erase` = 0.
- `expose` stays high for exactly `exp_time` cycles, from edge E0 to edge E0+exp_time.
- READ spans 2·ROWS cycles:
  - `nre[0]` falls at E0+exp_time.
  - The first `adc` pulse starts at E0+exp_time+1.
- `frame_done` and the return to IDLE occur at E0+exp_time+2·ROWS. At that edge `erase` = 1 and `busy` = 0, and `frame_done` is high for that cycle only.
- Total frame length is exp_time + 2·ROWS cycles.
- Exposure takes effect one cycle after the `exp_inc`/`exp_dec` sample. An `init` on the same edge uses the pre-update value.

## Configuration
- `CAMERA_CONT_EN` defined:
  - The `cont` port exists.
  - If `cont` = 1 on the last READ cycle, the FSM goes to EXPOSE instead of IDLE.
  - `frame_done` still pulses; `busy` stays 1; `exp_cnt` reloads from `exp_time`.
  - The `erase` = 1 cycle is skipped between frames.
- `CAMERA_CONT_EN` undefined: the `cont` port is absent and every frame ends in IDLE.

## Structure
- Package `camera_pkg` holds:
  - the state typedef (IDLE/EXPOSE/READ);
  - the `ROW_CYCLES` = 2 constant;
  - a helper for the row-counter width, max(1, clog2(ROWS)).
- Sub-module `exposure_reg`: a saturating up/down register.
  - Parameters: EXP_W, EXP_MIN, EXP_MAX, EXP_RESET.
  - Inputs: inc, dec, enable.
  - Output: value.
  - It is instantiated once, with enable = !busy.
- Top level contains the FSM, `exp_cnt`, the row counter and the phase bit.

## Test plan
- Reset, then 20 cycles of `exp_inc`, then `init` (ROWS=2, EXP_RESET=2): `exp_time` = 22; `expose` high for exactly 22 cycles; `nre` = 2'b10,2'b10,2'b01,2'b01; `adc` = 0,1,0,1; `frame_done` pulses once; total frame 26 cycles.
- Saturation: `exp_inc` held for 40 cycles → `exp_time` = 30. `exp_dec` held for 40 cycles → `exp_time` = 2. Both high for 5 cycles → value unchanged.
- Lockout: `exp_inc` and a second `init` pulsed during EXPOSE → frame timing unchanged and `exp_time` unchanged after IDLE.
- Reset mid-READ with `nre[1]` low → immediately `nre` = all 1s, `adc` = 0, `erase` = 1, `busy` = 0, `exp_time` = 2.
- ROWS=4, `exp_time` = 3: READ lasts 8 cycles; `nre[3..0]` walks one-cold from 1110 to 0111; 4 `adc` pulses.
- `CAMERA_CONT_EN`, `cont` = 1: back-to-back frames with `erase` never high and `frame_done` every exp_time+2·ROWS cycles. Dropping `cont` ends the sequence in IDLE after the current frame.
